// File: rtl/fb_pkg.sv
// Shared definitions for the frame-buffer sequencer: FSM state encoding and
// default geometry of the stored greyscale frame.
package fb_pkg;

    // Default frame geometry: 600 x 400 pixels, 4-bit greyscale.
    localparam int DEFAULT_FRAME_PIXELS = 240000;
    localparam int DEFAULT_ADDR_W       = 18;
    localparam int DEFAULT_PIX_W        = 4;

    // Width of the completed-frame counter.
    localparam int FRAME_COUNT_W = 8;

    // Sequencer states.
    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_VSYNC = 2'd1,
        CAPTURE    = 2'd2,
        PROCESS    = 2'd3
    } fbState_e;

    // Address of the final pixel of a frame, sized to the BRAM address bus.
    function automatic logic [31:0] lastPixelAddr(input int framePixels);
        return 32'(framePixels - 1);
    endfunction

endpackage

// File: rtl/vsync_edge.sv
// Rising-edge detector for the camera frame marker. The marker is assumed to
// be synchronous to clk; the pulse is combinational from the current input
// and the previous-cycle sample.
module vsync_edge (
    input  logic clk,
    input  logic reset,
    input  logic cam_vsync,
    output logic risePulse
);

    logic vsyncPrev;

    // Remember last cycle's marker level so a low-to-high step can be seen.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vsyncPrev <= 1'b0;
        end else begin
            // NOTE: flops always use non-blocking '<=' so every register in
            // the design updates from the same pre-edge values.
            vsyncPrev <= cam_vsync;
        end
    end

    assign risePulse = cam_vsync & ~vsyncPrev;

endmodule

// File: rtl/fb_frame_sequencer.sv
// Frame-buffer sequencer: waits for start, synchronises to the camera frame
// marker, streams one frame of pixels into BRAM, then hands the BRAM port to
// a processor until it signals completion.
// Optional build macro FB_CONTINUOUS_EN: after the processor finishes, the
// sequencer re-arms for the next frame instead of returning to IDLE.
module fb_frame_sequencer
    import fb_pkg::*;
#(
    parameter int FRAME_PIXELS = DEFAULT_FRAME_PIXELS,
    parameter int ADDR_W       = DEFAULT_ADDR_W,
    parameter int PIX_W        = DEFAULT_PIX_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic              cam_vsync,
    input  logic              cam_valid,
    input  logic [PIX_W-1:0]  cam_pixel,
    input  logic              proc_req,
    input  logic              proc_we,
    input  logic [ADDR_W-1:0] proc_addr,
    input  logic [PIX_W-1:0]  proc_wdata,
    input  logic              proc_done,
    output logic              proc_gnt,
    output logic              proc_rvalid,
    output logic [ADDR_W-1:0] bram_addr,
    output logic              bram_we,
    output logic [PIX_W-1:0]  bram_din,
    output logic              busy,
    output logic              done,
    output logic              frame_err,
    output logic [7:0]        frame_count
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(lastPixelAddr(FRAME_PIXELS));

    fbState_e          state;
    logic [ADDR_W-1:0] wrCount;
    logic              vsyncRise;
    logic              captureWrite;
    logic              lastPixel;
    logic [1:0]        readPipe;

    vsync_edge uVsyncEdge (
        .clk       (clk),
        .reset     (reset),
        .cam_vsync (cam_vsync),
        .risePulse (vsyncRise)
    );

    // The processor owns the BRAM port only while a frame is being processed.
    assign proc_gnt = proc_req && (state == PROCESS);

    // A camera pixel is stored only in CAPTURE, and not in a cycle that
    // restarts the frame or aborts the sequence.
    assign captureWrite = (state == CAPTURE) && cam_valid && !vsyncRise && !abort;
    assign lastPixel    = (wrCount == LAST_ADDR);

    assign busy        = (state != IDLE);
    assign proc_rvalid = readPipe[1];

    // Sequencer FSM: state, write counter, completion pulse and frame status.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            wrCount     <= '0;
            done        <= 1'b0;
            frame_err   <= 1'b0;
            frame_count <= '0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                // Abort wins over every transition; status registers are kept.
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            state <= WAIT_VSYNC;
                        end
                    end
                    WAIT_VSYNC: begin
                        if (vsyncRise) begin
                            state   <= CAPTURE;
                            wrCount <= '0;
                        end
                    end
                    CAPTURE: begin
                        if (vsyncRise) begin
                            // Short frame: flag it and restart on the new one.
                            frame_err <= 1'b1;
                            wrCount   <= '0;
                        end else if (cam_valid) begin
                            wrCount <= wrCount + ADDR_W'(1);
                            if (lastPixel) begin
                                state <= PROCESS;
                            end
                        end
                    end
                    PROCESS: begin
                        if (proc_done) begin
                            done        <= 1'b1;
                            frame_count <= frame_count + 8'd1;
`ifdef FB_CONTINUOUS_EN
                            state       <= WAIT_VSYNC;
`else
                            state       <= IDLE;
`endif
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // BRAM port mux: registers either the capture write or a granted processor
    // access, and tracks reads through the register + BRAM latency.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the BRAM port registers are reset so the memory never sees
            // a stray write strobe coming out of reset; the BRAM array itself
            // has no reset.
            bram_addr <= '0;
            bram_we   <= 1'b0;
            bram_din  <= '0;
            readPipe  <= '0;
        end else begin
            bram_we  <= 1'b0;
            readPipe <= {readPipe[0], proc_gnt && !proc_we};
            if (captureWrite) begin
                bram_addr <= wrCount;
                bram_din  <= cam_pixel;
                bram_we   <= 1'b1;
            end else if (proc_gnt) begin
                bram_addr <= proc_addr;
                bram_din  <= proc_wdata;
                bram_we   <= proc_we;
            end
        end
    end

endmodule
